// File: rtl/result_serializer.sv
// rtl/result_serializer.sv - double-banked capture of per-core results, streamed one word per beat
module result_serializer #(
  parameter  int CORENUM = 16,
  parameter  int DW      = 32,
  localparam int IW      = $clog2(CORENUM)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CORENUM-1:0]    core_done,
  input  logic [CORENUM*DW-1:0] core_data,
  input  logic                  dst_ready,
  output logic                  dst_valid,
  output logic [DW-1:0]         dst_data,
  output logic                  dst_last,
  output logic                  busy,
  output logic                  ovf,
  output logic [15:0]           batch_cnt
);

  localparam logic [IW-1:0] LAST_IDX = IW'(CORENUM - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t              state, state_nxt;
  logic [IW-1:0]       idx, idx_nxt;
  logic [DW-1:0]       cap_data [CORENUM];
  logic [CORENUM-1:0]  cap_mask;
  logic [DW-1:0]       shadow   [CORENUM];

  logic full;
  logic hs;
  logic last_hs;
  logic shadow_free;
  logic xfer;
  logic ovf_hit;

  // Handshake, bank-transfer and overflow decode from registered state and inputs
  always_comb begin
    full        = &cap_mask;
    hs          = dst_valid && dst_ready;
    last_hs     = hs && (idx == LAST_IDX);
    shadow_free = (state == IDLE) || last_hs;
    xfer        = full && shadow_free;
    ovf_hit     = (|(core_done & cap_mask)) && !xfer;
  end

  // Next-state and beat index; a transfer on the last beat restarts at word 0 with no gap
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      IDLE: begin
        if (xfer) begin
          state_nxt = SEND;
          idx_nxt   = '0;
        end
      end
      SEND: begin
        if (hs) begin
          if (idx == LAST_IDX) begin
            idx_nxt   = '0;
            state_nxt = xfer ? SEND : IDLE;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Capture bank: first word per core wins; a new word in a transfer cycle starts the next batch
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_mask <= '0;
      for (int i = 0; i < CORENUM; i++) cap_data[i] <= '0;
    end else begin
      for (int i = 0; i < CORENUM; i++) begin
        if (core_done[i] && (xfer || !cap_mask[i])) begin
          cap_data[i] <= core_data[i*DW +: DW];
          cap_mask[i] <= 1'b1;
        end else if (xfer) begin
          cap_mask[i] <= 1'b0;
        end
      end
    end
  end

  // Shadow bank takes the pre-edge capture contents on transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CORENUM; i++) shadow[i] <= '0;
    end else if (xfer) begin
      for (int i = 0; i < CORENUM; i++) shadow[i] <= cap_data[i];
    end
  end

  // Sticky overflow and completed-batch counter
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf       <= 1'b0;
      batch_cnt <= '0;
    end else begin
      if (ovf_hit) ovf <= 1'b1;
      if (last_hs) batch_cnt <= batch_cnt + 16'd1;
    end
  end

  assign dst_valid = (state == SEND);
  assign dst_data  = shadow[idx];
  assign dst_last  = dst_valid && (idx == LAST_IDX);
  assign busy      = (state == SEND) || (|cap_mask);

endmodule

// File: tb/tb_result_serializer.sv
// tb/tb_result_serializer.sv - randomized and directed bench against a queue-based batch model
module tb_result_serializer;

  localparam int N  = 4;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    core_done;
  logic [N*DW-1:0] core_data;
  logic            dst_ready;
  logic            dst_valid;
  logic [DW-1:0]   dst_data;
  logic            dst_last;
  logic            busy;
  logic            ovf;
  logic [15:0]     batch_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // model: pending capture words, and the words still to be emitted for the batch in flight
  logic [DW-1:0] m_cap [N];
  logic [N-1:0]  m_mask;
  logic [DW-1:0] m_sq [$];
  logic          m_ovf;
  logic [15:0]   m_bcnt;

  result_serializer #(.CORENUM(N), .DW(DW)) dut (
    .clk(clk), .rst(rst), .core_done(core_done), .core_data(core_data),
    .dst_ready(dst_ready), .dst_valid(dst_valid), .dst_data(dst_data),
    .dst_last(dst_last), .busy(busy), .ovf(ovf), .batch_cnt(batch_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance the model by one clock from the rules: a full bank moves to the output once
  // the previous batch has nothing left to emit after this cycle's handshake.
  task automatic model_step(input logic r, input logic [N-1:0] d,
                            input logic [N*DW-1:0] data, input logic rdy);
    logic sending, hsm, fullm, freem, xf;
    logic [N-1:0] old_mask;
    if (r) begin
      m_sq.delete();
      m_mask = '0;
      m_ovf  = 1'b0;
      m_bcnt = '0;
      for (int i = 0; i < N; i++) m_cap[i] = '0;
    end else begin
      sending  = (m_sq.size() > 0);
      hsm      = sending && rdy;
      fullm    = (m_mask == {N{1'b1}});
      freem    = !sending || (hsm && m_sq.size() == 1);
      xf       = fullm && freem;
      old_mask = m_mask;
      if (hsm) begin
        void'(m_sq.pop_front());
        if (m_sq.size() == 0) m_bcnt = m_bcnt + 16'd1;
      end
      if (xf) begin
        for (int i = 0; i < N; i++) m_sq.push_back(m_cap[i]);
        m_mask = '0;
      end
      for (int i = 0; i < N; i++) begin
        if (d[i]) begin
          if (xf || !old_mask[i]) begin
            m_cap[i]  = data[i*DW +: DW];
            m_mask[i] = 1'b1;
          end else begin
            m_ovf = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    check("valid", {31'd0, dst_valid}, {31'd0, m_sq.size() > 0});
    if (m_sq.size() > 0) begin
      check("data", dst_data, m_sq[0]);
      check("last", {31'd0, dst_last}, {31'd0, m_sq.size() == 1});
    end else begin
      check("last_idle", {31'd0, dst_last}, 32'd0);
    end
    check("busy", {31'd0, busy}, {31'd0, (m_sq.size() > 0) || (m_mask != '0)});
    check("ovf", {31'd0, ovf}, {31'd0, m_ovf});
    check("batch_cnt", {16'd0, batch_cnt}, {16'd0, m_bcnt});
  endtask

  task automatic step(input logic r, input logic [N-1:0] d,
                      input logic [N*DW-1:0] data, input logic rdy);
    rst       = r;
    core_done = d;
    core_data = data;
    dst_ready = rdy;
    model_step(r, d, data, rdy);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  function automatic logic [N*DW-1:0] words(input logic [31:0] w0, input logic [31:0] w1,
                                            input logic [31:0] w2, input logic [31:0] w3);
    return {w3, w2, w1, w0};
  endfunction

  task automatic idle(input int n, input logic rdy);
    for (int k = 0; k < n; k++) step(1'b0, '0, '0, rdy);
  endtask

  initial begin
    logic [N*DW-1:0] a_words;
    a_words = words(32'hA0, 32'hA1, 32'hA2, 32'hA3);

    step(1'b1, '0, '0, 1'b0);
    step(1'b1, '0, '0, 1'b0);
    check("reset_data", dst_data, 32'd0);

    // single batch, all cores done together
    step(1'b0, 4'hF, a_words, 1'b1);
    check("lat_edge0_valid", {31'd0, dst_valid}, 32'd0);
    step(1'b0, '0, '0, 1'b1);
    check("lat_edge1_beat0", dst_data, 32'hA0);
    step(1'b0, '0, '0, 1'b1);
    step(1'b0, '0, '0, 1'b1);
    step(1'b0, '0, '0, 1'b1);
    check("beat3_last", {31'd0, dst_last}, 32'd1);
    check("beat3_data", dst_data, 32'hA3);
    idle(2, 1'b1);
    check("single_bcnt", {16'd0, batch_cnt}, 32'd1);

    // staggered completion, ready toggling
    step(1'b0, 4'h8, words(0, 0, 0, 32'hB3), 1'b1);
    step(1'b0, 4'h2, words(0, 32'hB1, 0, 0), 1'b0);
    step(1'b0, 4'h1, words(32'hB0, 0, 0, 0), 1'b1);
    step(1'b0, 4'h4, words(0, 0, 32'hB2, 0), 1'b0);
    for (int k = 0; k < 10; k++) step(1'b0, '0, '0, k[0] ? 1'b0 : 1'b1);
    idle(2, 1'b1);

    // back-to-back batches
    step(1'b0, 4'hF, words(32'hC0, 32'hC1, 32'hC2, 32'hC3), 1'b1);
    step(1'b0, '0, '0, 1'b1);
    step(1'b0, 4'hF, words(32'hD0, 32'hD1, 32'hD2, 32'hD3), 1'b1);
    idle(10, 1'b1);

    // duplicate done on core 1
    step(1'b0, 4'h2, words(0, 32'h11, 0, 0), 1'b1);
    step(1'b0, 4'h2, words(0, 32'h22, 0, 0), 1'b1);
    check("dup_ovf", {31'd0, ovf}, 32'd1);
    step(1'b0, 4'hD, words(32'h10, 0, 32'h12, 32'h13), 1'b1);
    step(1'b0, '0, '0, 1'b1);
    step(1'b0, '0, '0, 1'b1);
    check("dup_core1_word", dst_data, 32'h11);
    idle(6, 1'b1);

    // core 0 done in the transfer cycle
    step(1'b1, '0, '0, 1'b1);
    step(1'b0, 4'hF, words(32'hE0, 32'hE1, 32'hE2, 32'hE3), 1'b1);
    step(1'b0, 4'h1, words(32'hF0, 0, 0, 0), 1'b1);
    check("xfer_beat0_old", dst_data, 32'hE0);
    check("xfer_no_ovf", {31'd0, ovf}, 32'd0);
    step(1'b0, 4'hE, words(0, 32'hF1, 32'hF2, 32'hF3), 1'b1);
    idle(12, 1'b1);

    // reset in the middle of a stream
    step(1'b0, 4'hF, a_words, 1'b1);
    idle(3, 1'b1);
    step(1'b1, '0, '0, 1'b1);
    check("rst_mid_valid", {31'd0, dst_valid}, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_bcnt", {16'd0, batch_cnt}, 32'd0);
    step(1'b0, 4'hF, words(32'h70, 32'h71, 32'h72, 32'h73), 1'b1);
    step(1'b0, '0, '0, 1'b1);
    check("fresh_beat0", dst_data, 32'h70);
    idle(6, 1'b1);

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      logic [N-1:0] d;
      for (int i = 0; i < N; i++) d[i] = ($urandom_range(0, 2) == 0);
      step(($urandom_range(0, 499) == 0), d,
           {$urandom, $urandom, $urandom, $urandom}, ($urandom_range(0, 9) < 7));
    end
    idle(20, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/result_serializer.md
# result_serializer

Collects one DW-bit result word from each of CORENUM processing cores and serializes the batch onto an AXI-Stream-style output, one word per beat. It sits directly downstream of the core array, on the output path toward the DMA. A capture bank accumulates results while a shadow bank streams the previous batch. Back-to-back batches therefore flow without bubbles on the capture side.

## Interface
- CORENUM, 16, number of cores; must be ≥ 2.
- DW, 32, result word width per core.
- IW, $clog2(CORENUM), beat index width (derived, not overridden).

- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  reset, synchronous, active-high.
- core_done  in  CORENUM  per-core one-cycle strobe; core i's result is valid this cycle.
- core_data  in  CORENUM*DW  packed results; core i occupies bits [i*DW +: DW].
- dst_ready  in  1  downstream accept.
- dst_valid  out  1  output beat valid.
- dst_data  out  DW  output beat payload.
- dst_last  out  1  final beat of a batch.
- busy  out  1  high when state==SEND or cap_mask≠0.
- ovf  out  1  sticky overflow flag; cleared only by rst.
- batch_cnt  out  16  count of completed batches; wraps 0xFFFF→0.

## Operation
- Capture bank: cap_data[CORENUM] and cap_mask[CORENUM].
  - core_done[i] with cap_mask[i]==0: cap_data[i] ← core_data slice i, cap_mask[i] ← 1.
  - core_done[i] with cap_mask[i]==1 and no transfer this cycle: word dropped (first value kept), ovf ← 1.
- full = &cap_mask (registered mask, not including this cycle's core_done).
- Transfer fires when full && shadow_free.
  - shadow_free = (state==IDLE) || (state==SEND && dst_valid && dst_ready && idx==CORENUM-1).
  - On transfer: shadow ← cap_data, cap_mask ← 0, state ← SEND, idx ← 0.
  - core_done[i] in a transfer cycle: shadow receives the old cap_data[i]; cap_data[i] takes the new word; cap_mask[i] ← 1 (set wins over clear; no ovf).
- FSM, two states:
  - IDLE: dst_valid=0; go to SEND on transfer.
  - SEND: dst_valid=1. A handshake (dst_valid && dst_ready) advances idx.
  - Handshake at idx==CORENUM-1: batch_cnt += 1. Then, if a transfer fires the same cycle, stay in SEND with idx ← 0; otherwise go to IDLE.
- Output mapping: dst_data = shadow[idx]; dst_last = dst_valid && idx==CORENUM-1. Beats are emitted in ascending core order.
- AXI rules: once asserted, dst_valid, dst_data and dst_last stay stable until the handshake. dst_valid never depends combinationally on dst_ready.
- Full with the shadow bank still sending: capture bank holds; further core_done on already-captured cores raise ovf.

## Timing
- Reset values: state=IDLE, idx=0, cap_mask=0, dst_valid=0, dst_last=0, dst_data=0 (shadow cleared), busy=0, ovf=0, batch_cnt=0. Reset mid-batch discards both banks; no partial batch is emitted.
- Latency: last missing core_done sampled at edge E0 → full during the next cycle → transfer at E1 → dst_valid=1 with word 0 after E1 (two edges).
- Throughput: with dst_ready held high, one beat per cycle. CORENUM beats take CORENUM cycles.
- Back-to-back: the next batch's beat 0 follows the previous dst_last beat with zero gap, provided full at that cycle.
- All outputs are registered or decoded from registered state only.
- ovf and batch_cnt update on the edge following the triggering event.

## Test plan
- Single batch, CORENUM=4, DW=32: core i sends 0xA0+i, all in one cycle, dst_ready=1 → dst_data 0xA0, 0xA1, 0xA2, 0xA3 on 4 consecutive cycles, dst_valid first high 2 edges after core_done, dst_last only on 0xA3, batch_cnt=1, ovf=0.
- Staggered done in order 3,1,0,2, dst_ready toggling 1,0,1,0 → data held stable while ready=0, order 0..3 preserved, 4 handshakes total.
- Two batches, second completing while the first streams, dst_ready=1 → 8 beats, no gap between the first dst_last and the second batch's beat 0, batch_cnt=2.
- Core 1 done twice (values 0x11 then 0x22) before the batch completes → ovf=1 (sticky), emitted word for core 1 = 0x11.
- core_done[0]=1 exactly in the transfer cycle → current batch carries the old word, new word counts toward the next batch, ovf=0.
- rst asserted mid-stream at beat 2 → next cycle dst_valid=0, busy=0, batch_cnt=0; a fresh batch afterwards streams from beat 0.
